// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - field indices, FSM encoding and calendar helpers for time setting
package clock_pkg;

  localparam logic [2:0] FLD_SEC   = 3'd0;
  localparam logic [2:0] FLD_MIN   = 3'd1;
  localparam logic [2:0] FLD_HOUR  = 3'd2;
  localparam logic [2:0] FLD_DAY   = 3'd3;
  localparam logic [2:0] FLD_MONTH = 3'd4;
  localparam logic [2:0] FLD_YEAR  = 3'd5;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SET    = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  localparam logic [4:0] MONTH_DAYS [12] = '{
    5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30,
    5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31
  };

  function automatic logic is_leap(input logic [15:0] year);
    return (year[1:0] == 2'b00) &&
           (((year % 16'd100) != 16'd0) || ((year % 16'd400) == 16'd0));
  endfunction

  function automatic logic [10:0] days_in_month(input logic [15:0] year,
                                                input logic [5:0]  month);
    logic [4:0] d;
    logic [3:0] idx;
    idx = 4'(month - 6'd1);
    // Out-of-range months (only reachable from bad live input) fall back to 31.
    if (month == 6'd0 || month > 6'd12) d = 5'd31;
    else if (month == 6'd2 && is_leap(year)) d = 5'd29;
    else d = MONTH_DAYS[idx];
    return {6'd0, d};
  endfunction

  function automatic logic [15:0] step_wrap(input logic [15:0] val,
                                            input logic [15:0] lo,
                                            input logic [15:0] hi,
                                            input logic        inc);
    if (inc) return (val >= hi || val < lo) ? lo : val + 16'd1;
    else     return (val <= lo || val > hi) ? hi : val - 16'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer, level debouncer and rising-edge press pulse
module btn_debounce #(
  parameter logic [19:0] DEBOUNCE_CYC = 20'd500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        db_q, db_d;
  logic        db_dly_q, db_dly_d;
  logic [19:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    db_d     = db_q;
    db_dly_d = db_q;
    cnt_d    = 20'd0;
    // Counter only runs while the synchronized level disagrees with the accepted one.
    if (sync2_q != db_q) begin
      if (cnt_q + 20'd1 >= DEBOUNCE_CYC) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 20'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      cnt_q    <= 20'd0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      db_q     <= db_d;
      db_dly_q <= db_dly_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press = db_q & ~db_dly_q;

endmodule

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - button-driven date/time editor with commit strobe and field blinking
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYC = 20'd500000,
  parameter int          TIMEOUT_S    = 30,
  parameter int          YEAR_MIN     = 2000,
  parameter int          YEAR_MAX     = 2099
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        middle,
  input  logic        sec_tick,
  input  logic        blink_tick,
  input  logic [15:0] cur_year,
  input  logic [5:0]  cur_month,
  input  logic [10:0] cur_day,
  input  logic [10:0] cur_hour,
  input  logic [10:0] cur_minute,
  input  logic [10:0] cur_second,
  output logic [15:0] set_year,
  output logic [5:0]  set_month,
  output logic [10:0] set_day,
  output logic [10:0] set_hour,
  output logic [10:0] set_minute,
  output logic [10:0] set_second,
  output logic        load,
  output logic        editing,
  output logic [5:0]  blink_mask
);

  localparam int IDLE_W = (TIMEOUT_S < 1) ? 1 : $clog2(TIMEOUT_S + 1);
  localparam logic [15:0] Y_MIN = 16'(YEAR_MIN);
  localparam logic [15:0] Y_MAX = 16'(YEAR_MAX);

  logic [4:0] btn_raw, btn_press;
  logic       press_mid, press_up, press_dn, press_lt, press_rt, any_press;

  assign btn_raw = {middle, up, down, left, right};

  for (genvar i = 0; i < 5; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (btn_raw[i]),
      .press   (btn_press[i])
    );
  end

  assign press_mid = btn_press[4];
  assign press_up  = btn_press[3];
  assign press_dn  = btn_press[2];
  assign press_lt  = btn_press[1];
  assign press_rt  = btn_press[0];
  assign any_press = |btn_press;

  state_e              state_q, state_d;
  logic [2:0]          fld_q, fld_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                phase_q, phase_d;
  logic [15:0]         year_q, year_d;
  logic [5:0]          month_q, month_d;
  logic [10:0]         day_q, day_d;
  logic [10:0]         hour_q, hour_d;
  logic [10:0]         min_q, min_d;
  logic [10:0]         sec_q, sec_d;
  logic [10:0]         dim_cur, dim_new;

  always_comb begin
    state_d = state_q;
    fld_d   = fld_q;
    idle_d  = idle_q;
    phase_d = phase_q;
    year_d  = year_q;
    month_d = month_q;
    day_d   = day_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    dim_cur = days_in_month(year_q, month_q);
    dim_new = dim_cur;

    unique case (state_q)
      ST_RUN: begin
        year_d  = cur_year;
        month_d = cur_month;
        day_d   = cur_day;
        hour_d  = cur_hour;
        min_d   = cur_minute;
        sec_d   = cur_second;
        fld_d   = FLD_YEAR;
        idle_d  = '0;
        phase_d = 1'b0;
        if (press_mid) state_d = ST_SET;
      end

      ST_SET: begin
        if (blink_tick) phase_d = ~phase_q;
        if (sec_tick)   idle_d  = idle_q + IDLE_W'(1);
        if (any_press)  idle_d  = '0;

        // Only the highest-priority press in a cycle takes effect.
        if (press_mid) begin
          state_d = ST_COMMIT;
          phase_d = 1'b0;
        end else if (press_up || press_dn) begin
          phase_d = 1'b0;
          unique case (fld_q)
            FLD_YEAR:  year_d  = step_wrap(year_q, Y_MIN, Y_MAX, press_up);
            FLD_MONTH: month_d = 6'(step_wrap({10'd0, month_q}, 16'd1, 16'd12, press_up));
            FLD_DAY:   day_d   = 11'(step_wrap({5'd0, day_q}, 16'd1, {5'd0, dim_cur}, press_up));
            FLD_HOUR:  hour_d  = 11'(step_wrap({5'd0, hour_q}, 16'd0, 16'd23, press_up));
            FLD_MIN:   min_d   = 11'(step_wrap({5'd0, min_q}, 16'd0, 16'd59, press_up));
            default:   sec_d   = 11'(step_wrap({5'd0, sec_q}, 16'd0, 16'd59, press_up));
          endcase
          if (fld_q == FLD_YEAR || fld_q == FLD_MONTH) begin
            dim_new = days_in_month(year_d, month_d);
            if (day_q > dim_new) day_d = dim_new;
          end
        end else if (press_lt) begin
          fld_d = (fld_q >= FLD_YEAR) ? FLD_SEC : fld_q + 3'd1;
        end else if (press_rt) begin
          fld_d = (fld_q == FLD_SEC) ? FLD_YEAR : fld_q - 3'd1;
        end else if (sec_tick && idle_q == IDLE_W'(TIMEOUT_S - 1)) begin
          state_d = ST_RUN;
          phase_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_RUN;
        phase_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      fld_q   <= FLD_YEAR;
      idle_q  <= '0;
      phase_q <= 1'b0;
      year_q  <= Y_MIN;
      month_q <= 6'd1;
      day_q   <= 11'd1;
      hour_q  <= 11'd0;
      min_q   <= 11'd0;
      sec_q   <= 11'd0;
    end else begin
      state_q <= state_d;
      fld_q   <= fld_d;
      idle_q  <= idle_d;
      phase_q <= phase_d;
      year_q  <= year_d;
      month_q <= month_d;
      day_q   <= day_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
    end
  end

  assign set_year   = year_q;
  assign set_month  = month_q;
  assign set_day    = day_q;
  assign set_hour   = hour_q;
  assign set_minute = min_q;
  assign set_second = sec_q;
  assign load       = (state_q == ST_COMMIT);
  assign editing    = (state_q != ST_RUN);
  assign blink_mask = (state_q == ST_SET && phase_q) ? (6'd1 << fld_q) : 6'd0;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - directed self-checking bench for time_set_ctrl
module tb_time_set_ctrl;

  localparam logic [19:0] DEB = 20'd4;
  localparam int TMO  = 3;
  localparam int HOLD = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, middle = 1'b0;
  logic        sec_tick = 1'b0, blink_tick = 1'b0;
  logic [15:0] cur_year = 16'd2024;
  logic [5:0]  cur_month = 6'd2;
  logic [10:0] cur_day = 11'd29, cur_hour = 11'd13, cur_minute = 11'd0, cur_second = 11'd59;
  logic [15:0] set_year;
  logic [5:0]  set_month;
  logic [10:0] set_day, set_hour, set_minute, set_second;
  logic        load, editing;
  logic [5:0]  blink_mask;

  int checks = 0;
  int failures = 0;
  int load_cnt = 0;
  int load_snap;
  logic [15:0] ld_year;
  logic [5:0]  ld_month;
  logic [10:0] ld_day, ld_hour, ld_minute, ld_second;
  logic        found;

  time_set_ctrl #(
    .DEBOUNCE_CYC (DEB),
    .TIMEOUT_S    (TMO),
    .YEAR_MIN     (2000),
    .YEAR_MAX     (2099)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .middle     (middle),
    .sec_tick   (sec_tick),
    .blink_tick (blink_tick),
    .cur_year   (cur_year),
    .cur_month  (cur_month),
    .cur_day    (cur_day),
    .cur_hour   (cur_hour),
    .cur_minute (cur_minute),
    .cur_second (cur_second),
    .set_year   (set_year),
    .set_month  (set_month),
    .set_day    (set_day),
    .set_hour   (set_hour),
    .set_minute (set_minute),
    .set_second (set_second),
    .load       (load),
    .editing    (editing),
    .blink_mask (blink_mask)
  );

  always #5 clk = ~clk;

  // Plays the time counter: captures whatever is presented on a load strobe.
  always @(negedge clk) begin
    if (load) begin
      load_cnt  = load_cnt + 1;
      ld_year   = set_year;
      ld_month  = set_month;
      ld_day    = set_day;
      ld_hour   = set_hour;
      ld_minute = set_minute;
      ld_second = set_second;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // m = {middle, up, down, left, right}
  task automatic push(input logic [4:0] m);
    {middle, up, down, left, right} = m;
    step(HOLD);
    {middle, up, down, left, right} = 5'b0;
    step(HOLD);
  endtask

  task automatic pulse_sec();
    sec_tick = 1'b1;
    step(1);
    sec_tick = 1'b0;
    step(1);
  endtask

  task automatic pulse_blink();
    blink_tick = 1'b1;
    step(1);
    blink_tick = 1'b0;
    step(1);
  endtask

  task automatic set_cur(input int y, input int mo, input int d, input int h, input int mi, input int s);
    cur_year = 16'(y); cur_month = 6'(mo); cur_day = 11'(d);
    cur_hour = 11'(h); cur_minute = 11'(mi); cur_second = 11'(s);
    step(2);
  endtask

  localparam logic [4:0] B_MID = 5'b10000;
  localparam logic [4:0] B_UP  = 5'b01000;
  localparam logic [4:0] B_DN  = 5'b00100;
  localparam logic [4:0] B_LT  = 5'b00010;
  localparam logic [4:0] B_RT  = 5'b00001;

  initial begin
    step(3);
    check_eq("rst_year", set_year, 2000);
    check_eq("rst_month", set_month, 1);
    check_eq("rst_day", set_day, 1);
    check_eq("rst_hms", {set_hour, set_minute, set_second}, 0);
    check_eq("rst_load", load, 0);
    check_eq("rst_editing", editing, 0);
    check_eq("rst_blink", blink_mask, 0);

    rst_n = 1'b1;
    step(2);
    check_eq("run_track_year", set_year, 2024);
    check_eq("run_track_day", set_day, 29);

    // Leap-day clamp on year change, then commit.
    push(B_MID);
    check_eq("set_editing", editing, 1);
    cur_year = 16'd2030;
    step(2);
    check_eq("set_holds_year", set_year, 2024);
    pulse_blink();
    check_eq("blink_year", blink_mask, 6'b100000);
    push(B_UP);
    check_eq("phase_reset", blink_mask, 0);
    check_eq("year_inc", set_year, 2025);
    check_eq("day_clamp", set_day, 28);
    push(B_MID);
    check_eq("commit1_cnt", load_cnt, 1);
    check_eq("commit1_year", ld_year, 2025);
    check_eq("commit1_month", ld_month, 2);
    check_eq("commit1_day", ld_day, 28);
    check_eq("commit1_hour", ld_hour, 13);
    check_eq("commit1_editing", editing, 0);

    // Wrap boundaries on year, minute, hour and field index.
    set_cur(2099, 6, 15, 0, 59, 30);
    push(B_MID);
    push(B_UP);
    check_eq("year_wrap", set_year, 2000);
    push(B_LT);
    push(B_LT);
    pulse_blink();
    check_eq("blink_minute", blink_mask, 6'b000010);
    pulse_blink();
    check_eq("blink_off", blink_mask, 0);
    push(B_UP);
    check_eq("minute_wrap", set_minute, 0);
    check_eq("hour_no_carry", set_hour, 0);
    push(B_LT);
    push(B_DN);
    check_eq("hour_wrap", set_hour, 23);
    push(B_RT);
    push(B_RT);
    push(B_RT);
    pulse_blink();
    check_eq("field_wrap_right", blink_mask, 6'b100000);
    pulse_blink();
    push(B_MID);
    check_eq("commit2_cnt", load_cnt, 2);
    check_eq("commit2_year", ld_year, 2000);
    check_eq("commit2_hour", ld_hour, 23);
    check_eq("commit2_minute", ld_minute, 0);
    check_eq("commit2_second", ld_second, 30);
    check_eq("commit2_day", ld_day, 15);

    // Middle beats up in the same cycle.
    set_cur(2050, 3, 10, 8, 20, 0);
    push(B_MID);
    push(B_MID | B_UP);
    check_eq("prio_cnt", load_cnt, 3);
    check_eq("prio_year", ld_year, 2050);
    check_eq("prio_editing", editing, 0);

    // Bounce rejection, then idle timeout.
    set_cur(2010, 7, 4, 1, 2, 3);
    push(B_MID);
    for (int i = 0; i < 10; i++) begin
      up = 1'b1;
      step(2);
      up = 1'b0;
      step(2);
    end
    push(B_UP);
    check_eq("bounce_one_inc", set_year, 2011);
    pulse_sec();
    pulse_sec();
    check_eq("timeout_not_yet", editing, 1);
    pulse_sec();
    check_eq("timeout_editing", editing, 0);
    check_eq("timeout_no_load", load_cnt, 3);
    step(2);
    check_eq("timeout_discard", set_year, 2010);

    // Reset while in COMMIT.
    set_cur(2040, 1, 1, 0, 0, 0);
    push(B_MID);
    push(B_LT);
    push(B_UP);
    middle = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (load) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("commit_reached", found, 1);
    rst_n = 1'b0;
    middle = 1'b0;
    #1;
    check_eq("rstc_load", load, 0);
    check_eq("rstc_editing", editing, 0);
    check_eq("rstc_blink", blink_mask, 0);
    check_eq("rstc_year", set_year, 2000);
    check_eq("rstc_md", {set_month, set_day}, {6'd1, 11'd1});
    check_eq("rstc_hms", {set_hour, set_minute, set_second}, 0);
    step(3);
    rst_n = 1'b1;
    load_snap = load_cnt;
    step(20);
    check_eq("rstc_no_load_after", load_cnt, load_snap);
    check_eq("rstc_run", editing, 0);
    check_eq("rstc_track", set_year, 2040);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
